// File: rtl/instr_mem_responder_pkg.sv
// Shared types and sizes for the instruction memory responder.
// Latency and backpressure are described with the modules that use these types.
package instr_mem_responder_pkg;

  localparam int MEM_DEPTH = 256;
  localparam int ADDR_W    = 8;
  localparam int BYTE_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_HI = 2'd1,
    RD_LO = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Address of the low byte of a big-endian instruction; wraps FF -> 00.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/instr_mem_responder_byte_ram.sv
// 256x8 program store: synchronous write, combinational read.
// Latency: a write lands at the clock edge; reads have zero latency; no backpressure.
module byte_ram
  import instr_mem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [MEM_DEPTH];

  // The contents deliberately survive reset so that a loaded program is kept.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_responder.sv
// Fetches a big-endian 16-bit instruction (two bytes) from byte_ram for a single request.
// Latency: resp_valid in the third cycle after acceptance; holds response until resp_ack; enable=0 freezes.
module instr_mem_responder
  import instr_mem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ack,
  output logic [BYTE_W-1:0] instruction_code_high,
  output logic [BYTE_W-1:0] instruction_code_low,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [BYTE_W-1:0] prog_data,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [BYTE_W-1:0] rd_data;
  logic              ram_we;
  logic              capture, load_hi, load_lo;

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    capture    = 1'b0;
    load_hi    = 1'b0;
    load_lo    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = enable;
        if (enable && req_valid) begin
          capture   = 1'b1;
          state_nxt = RD_HI;
        end
      end
      RD_HI: begin
        if (enable) begin
          load_hi   = 1'b1;
          state_nxt = RD_LO;
        end
      end
      RD_LO: begin
        if (enable) begin
          load_lo   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (enable && resp_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q                <= '0;
      instruction_code_high <= '0;
      instruction_code_low  <= '0;
    end else begin
      if (capture) addr_q <= req_addr;
      if (load_hi) instruction_code_high <= rd_data;
      if (load_lo) instruction_code_low  <= rd_data;
    end
  end

  // Loader writes only while idle, so a fetch can never see a half-updated instruction;
  // a write in the accepting cycle lands before RD_HI reads it.
  assign ram_we  = prog_we && (state == IDLE) && !reset;
  assign rd_addr = (state == RD_LO) ? next_addr(addr_q) : addr_q;
  assign busy    = (state != IDLE);

  byte_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 The module SHALL have one clock and a reset that is synchronous and active-high; there are no other clocks or asynchronous resets.
REQ-002 Port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port `reset`, input, 1 bit: synchronous active-high reset.
REQ-004 Port `enable`, input, 1 bit: when 0, the FSM and all registers hold, while program writes are still honoured per REQ-016.
REQ-005 Port `req_valid`, input, 1 bit: fetch request strobe.
REQ-006 Port `req_addr`, input, 8 bits: byte address of the instruction's high byte.
REQ-007 Port `req_ready`, output, 1 bit: the responder can accept a request.
REQ-008 Port `resp_valid`, output, 1 bit: instruction bytes are valid.
REQ-009 Port `resp_ack`, input, 1 bit: the fetch stage consumes the response.
REQ-010 Port `instruction_code_high`, output, 8 bits: instruction byte at `req_addr`.
REQ-011 Port `instruction_code_low`, output, 8 bits: instruction byte at `req_addr`+1.
REQ-012 Ports for the program loader:
- `prog_we`, input, 1 bit: byte write enable.
- `prog_addr`, input, 8 bits: write address.
- `prog_data`, input, 8 bits: write data.
REQ-013 Port `busy`, output, 1 bit: the FSM is not in IDLE.

Function
REQ-014 Storage SHALL be a 256 x 8 byte array, with instructions big-endian: high byte at the lower address.
REQ-015 The FSM SHALL have exactly four states: IDLE, RD_HI, RD_LO and RESP.
REQ-016 A program write SHALL take effect at the clock edge only when `prog_we`=1 and the state is IDLE; `prog_we` in any other state is ignored and dropped.
REQ-017 `req_ready` SHALL be 1 only in IDLE with `enable`=1.
REQ-018 A request is accepted when `req_valid`=1 and `req_ready`=1 at a clock edge; the address is then latched and the state goes IDLE->RD_HI.
REQ-019 In RD_HI, the FSM SHALL latch mem[addr] into the high register and go to RD_LO.
REQ-020 In RD_LO, the FSM SHALL latch mem[(addr+1) mod 256] into the low register and go to RESP.
- Address wraps: 8'hFF pairs with 8'h00.
REQ-021 In RESP, `resp_valid`=1 and the outputs are stable until `resp_ack`=1 is sampled; the FSM then returns to IDLE and `resp_valid` drops in the next cycle.
REQ-022 Latency: a request accepted at edge N SHALL give `resp_valid`=1 after edge N+2, i.e. visible in cycle N+3.
- Minimum back-to-back spacing: 4 cycles, since acceptance can occur again only from IDLE.
REQ-023 `prog_we` and an accepted request in the same IDLE cycle: the write SHALL commit first, so a read of that byte returns the new data.
REQ-024 `resp_ack` outside RESP SHALL be ignored.
REQ-025 `req_valid` outside IDLE SHALL be ignored; it is not queued.
REQ-026 `instruction_code_high` and `instruction_code_low` SHALL hold their last values after leaving RESP until the next RD_HI or RD_LO update.
REQ-027 Odd request addresses SHALL be legal, with no alignment check.

Reset
REQ-028 Reset SHALL take priority over `enable`, requests and program writes.
REQ-029 On reset, the FSM goes to IDLE and the following outputs are 0 after the edge:
- `resp_valid`, `busy`
- `instruction_code_high`, `instruction_code_low`
- the latched address
REQ-030 Reset SHALL NOT clear the memory array.
REQ-031 A reset asserted mid-transaction SHALL abort it, and no response is produced.
REQ-032 `req_ready`=1 SHALL be allowed the cycle after reset deasserts, provided `enable`=1.

Structure
REQ-033 A shared package SHALL hold:
- the FSM state enum, 2 bits: IDLE=0, RD_HI=1, RD_LO=2, RESP=3
- `MEM_DEPTH`=256
- `ADDR_W`=8
- `BYTE_W`=8
REQ-034 One sub-module, `byte_ram`, SHALL provide the 256x8 storage with a synchronous write port and a combinational read port; the FSM and handshake live in the top level.

Verification
REQ-035 Load mem[0C]=A5 and mem[0D]=3C; request addr 0C at edge N -> `resp_valid`=1 in cycle N+3, with high=A5 and low=3C.
REQ-036 Load mem[FF]=12 and mem[00]=34; request FF -> high=12, low=34 (wrap).
REQ-037 Hold `resp_ack`=0 for 5 cycles in RESP -> `resp_valid` and data stay stable; `req_ready`=0 throughout.
REQ-038 `prog_we` to 0C=77 together with a request to 0C in IDLE -> high=77; `prog_we` during RD_LO -> memory unchanged.
REQ-039 Assert `reset` in RD_LO -> next cycle: state IDLE, `resp_valid`=0, outputs 00, memory contents retained.
REQ-040 Drop `enable` in RD_HI for 3 cycles -> FSM holds; latency extends by 3 cycles, and the data is correct.
